ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl.sv | 78 +++++++
 tb/tb_ram_fifo_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a simple dual-port RAM with a registered read port.
// It tracks the pointers and occupancy, and strobes the RAM on each accepted push or pop.
module ram_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err,
    output logic                       udf_err,
    output logic                       wrEn,
    output logic                       rdEn,
    output logic [$clog2(DEPTH)-1:0]   wraddr,
    output logic [$clog2(DEPTH)-1:0]   rdaddr,
    output logic [WIDTH-1:0]           wrdata,
    input  logic [WIDTH-1:0]           rddata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_LEVEL));

    // Acceptance is decided from the pre-edge count, so a push and a pop at a boundary never both land
    assign push_ok = push & ~full & ~rst;
    assign pop_ok  = pop & ~empty & ~rst;

    assign wrEn     = push_ok;
    assign wraddr   = wr_ptr;
    assign wrdata   = push_data;
    assign rdEn     = pop_ok;
    assign rdaddr   = rd_ptr;
    assign pop_data = rddata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            pop_valid <= pop_ok;
            if (push & full)
                ovf_err <= 1'b1;
            if (pop & empty)
                udf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural dual-port RAM attached.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] count;
    logic       ovf_err;
    logic       udf_err;
    logic       wrEn;
    logic       rdEn;
    logic [2:0] wraddr;
    logic [2:0] rdaddr;
    logic [7:0] wrdata;
    logic [7:0] rddata;

    logic [7:0] mem [8];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .ovf_err(ovf_err), .udf_err(udf_err),
        .wrEn(wrEn), .rdEn(rdEn), .wraddr(wraddr), .rdaddr(rdaddr), .wrdata(wrdata),
        .rddata(rddata)
    );

    always @(posedge clk) begin
        if (wrEn)
            mem[wraddr] <= wrdata;
        if (rdEn)
            rddata <= mem[rdaddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'hEE;
        #1;
        total_cnt++;
        if ({wrEn, rdEn} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {wrEn, rdEn});
        else pass_cnt++;
        tick();
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        #1;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count);
        else pass_cnt++;
        total_cnt++;
        if ({empty, full, almost_full, pop_valid, ovf_err, udf_err} !== 6'b100000)
            $display("FAIL reset_flags got %b exp 100000",
                     {empty, full, almost_full, pop_valid, ovf_err, udf_err});
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'((i + 1) * 8'h11);
            #1;
            total_cnt++;
            if ({wrEn, wraddr, wrdata} !== {1'b1, 3'(i), 8'((i + 1) * 8'h11)})
                $display("FAIL fill_drive[%0d] got %b/%0d/%h exp 1/%0d/%h",
                         i, wrEn, wraddr, wrdata, i, 8'((i + 1) * 8'h11));
            else pass_cnt++;
            tick();
            push = 1'b0;
            total_cnt++;
            if ({count, almost_full, full} !== {4'(i + 1), (i + 1 >= 7), (i == 7)})
                $display("FAIL fill_status[%0d] got cnt=%0d af=%b full=%b exp cnt=%0d af=%b full=%b",
                         i, count, almost_full, full, i + 1, (i + 1 >= 7), (i == 7));
            else pass_cnt++;
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            #1;
            total_cnt++;
            if ({rdEn, rdaddr} !== {1'b1, 3'(i)})
                $display("FAIL drain_drive[%0d] got %b/%0d exp 1/%0d", i, rdEn, rdaddr, i);
            else pass_cnt++;
            tick();
            pop = 1'b0;
            total_cnt++;
            if ({pop_valid, pop_data, count} !== {1'b1, 8'((i + 1) * 8'h11), 4'(7 - i)})
                $display("FAIL drain_data[%0d] got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=%0d",
                         i, pop_valid, pop_data, count, 8'((i + 1) * 8'h11), 7 - i);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({pop_valid, empty, ovf_err, udf_err} !== 4'b0100)
            $display("FAIL drain_end got %b exp 0100", {pop_valid, empty, ovf_err, udf_err});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(i + 1);
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
            total_cnt++;
            if ({pop_valid, pop_data} !== {1'b1, 8'(i + 1)})
                $display("FAIL wrap_pre[%0d] got v=%b d=%h exp v=1 d=%h", i, pop_valid, pop_data, 8'(i + 1));
            else pass_cnt++;
        end
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_data = 8'(8'hA0 + i);
            #1;
            total_cnt++;
            if (wraddr !== 3'((5 + i) % 8))
                $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, wraddr, (5 + i) % 8);
            else pass_cnt++;
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
            total_cnt++;
            if ({pop_valid, pop_data} !== {1'b1, 8'(8'hA0 + i)})
                $display("FAIL wrap_data[%0d] got v=%b d=%h exp v=1 d=%h", i, pop_valid, pop_data, 8'(8'hA0 + i));
            else pass_cnt++;
        end
        total_cnt++;
        if (count !== 4'd0) $display("FAIL wrap_count got %0d exp 0", count);
        else pass_cnt++;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(8'h30 + i);
            tick();
        end
        push = 1'b1; pop = 1'b1; push_data = 8'hFF;
        #1;
        total_cnt++;
        if ({full, wrEn, rdEn} !== 3'b101)
            $display("FAIL full_simul_drive got %b exp 101", {full, wrEn, rdEn});
        else pass_cnt++;
        tick();
        push = 1'b0; pop = 1'b0;
        total_cnt++;
        if ({count, ovf_err, udf_err, pop_valid, pop_data} !== {4'd7, 1'b1, 1'b0, 1'b1, 8'h30})
            $display("FAIL full_simul_result got cnt=%0d ovf=%b udf=%b v=%b d=%h exp cnt=7 ovf=1 udf=0 v=1 d=30",
                     count, ovf_err, udf_err, pop_valid, pop_data);
        else pass_cnt++;
    endtask

    task automatic test_empty_simul();
        do_reset();
        push = 1'b1; pop = 1'b1; push_data = 8'h5A;
        #1;
        total_cnt++;
        if ({wrEn, rdEn} !== 2'b10) $display("FAIL empty_simul_drive got %b exp 10", {wrEn, rdEn});
        else pass_cnt++;
        tick();
        push = 1'b0; pop = 1'b0;
        total_cnt++;
        if ({count, udf_err, ovf_err, pop_valid} !== {4'd1, 1'b1, 1'b0, 1'b0})
            $display("FAIL empty_simul_result got cnt=%0d udf=%b ovf=%b v=%b exp cnt=1 udf=1 ovf=0 v=0",
                     count, udf_err, ovf_err, pop_valid);
        else pass_cnt++;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total_cnt++;
        if ({pop_valid, pop_data, count} !== {1'b1, 8'h5A, 4'd0})
            $display("FAIL empty_simul_readback got v=%b d=%h cnt=%0d exp v=1 d=5a cnt=0", pop_valid, pop_data, count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 8'(8'h40 + i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; pop = 1'b1; push_data = 8'(8'h44 + i);
            tick();
            total_cnt++;
            if ({count, pop_valid, pop_data} !== {4'd4, 1'b1, 8'(8'h40 + i)})
                $display("FAIL b2b[%0d] got cnt=%0d v=%b d=%h exp cnt=4 v=1 d=%h",
                         i, count, pop_valid, pop_data, 8'(8'h40 + i));
            else pass_cnt++;
        end
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'(8'h70 + i);
            tick();
        end
        push = 1'b0; pop = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({count, pop_valid, pop_data, rdEn} !== {4'd2, 1'b1, 8'h70, 1'b0})
            $display("FAIL reset_mid_pre got cnt=%0d v=%b d=%h rdEn=%b exp cnt=2 v=1 d=70 rdEn=0",
                     count, pop_valid, pop_data, rdEn);
        else pass_cnt++;
        tick();
        rst = 1'b0; pop = 1'b0;
        total_cnt++;
        if ({count, empty, pop_valid} !== {4'd0, 1'b1, 1'b0})
            $display("FAIL reset_mid_post got cnt=%0d empty=%b v=%b exp cnt=0 empty=1 v=0", count, empty, pop_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00;
        tick();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_simul();
        test_empty_simul();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
